// File: rtl/fp_pkg.sv
// Shared types and helpers for the fixed-point neuron datapath.
package fp_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE, OUT} state_t;

   // Headroom for MAX_TERMS products plus the bias, plus one sign bit.
   function automatic int acc_width(input int width, input int max_terms);
      return width + $clog2(max_terms + 1) + 1;
   endfunction

   function automatic int q_one(input int fp_positions);
      return 1 << fp_positions;
   endfunction

   localparam int Q_DEFAULT_FRAC = 4;
   localparam int ONE            = q_one(Q_DEFAULT_FRAC);

endpackage

// File: rtl/fp_saturate.sv
// Combinational clamp of an extended-width sum back to WIDTH.
// Also applies ReLU and flags any change to the value.
module fp_saturate
   import fp_pkg::*;
#(
   parameter int SIGN  = 1,
   parameter int WIDTH = 8,
   parameter int ACC_W = acc_width(8, 16),
   parameter int RELU  = 1
) (
   input  logic [ACC_W-1:0] acc,
   output logic [WIDTH-1:0] data,
   output logic             sat
);

   // In range when every bit above the result's MSB matches the sign
   // (signed) or is zero (unsigned).
   always_comb begin
      data = acc[WIDTH-1:0];
      sat  = 1'b0;
      if (SIGN != 0) begin
         if (acc[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){acc[ACC_W-1]}}) begin
            data = acc[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
            sat  = 1'b1;
         end
         if ((RELU != 0) && acc[ACC_W-1]) begin
            data = '0;
            sat  = 1'b1;
         end
      end else if (acc[ACC_W-1:WIDTH] != '0) begin
         data = '1;
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/fp_neuron_accum.sv
// Bias-seeded accumulator for a stream of fixed-point products, emitting
// one saturated, optionally ReLU'd activation per neuron.
module fp_neuron_accum
   import fp_pkg::*;
#(
   parameter int SIGN         = 1,
   parameter int WIDTH        = 8,
   parameter int FP_POSITIONS = 4,
   parameter int MAX_TERMS    = 16,
   parameter int RELU         = 1,
   parameter int TERM_W       = $clog2(MAX_TERMS + 1) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_product,
   input  logic              in_last,
   input  logic [WIDTH-1:0]  bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_sat,
   output logic [TERM_W-1:0] out_terms
);

   localparam int ACC_W = acc_width(WIDTH, MAX_TERMS);

   if (FP_POSITIONS < 0 || FP_POSITIONS >= WIDTH) begin : g_bad_q_format
      $error("FP_POSITIONS must lie within WIDTH");
   end

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [TERM_W-1:0]  terms_q, terms_d;
   logic [WIDTH-1:0]   out_data_q, out_data_d;
   logic               out_sat_q, out_sat_d;
   logic [TERM_W-1:0]  out_terms_q, out_terms_d;
   logic [WIDTH-1:0]   clamp_data;
   logic               clamp_sat;
   logic               beat;

   function automatic logic [ACC_W-1:0] ext(input logic [WIDTH-1:0] v);
      return {{(ACC_W-WIDTH){(SIGN != 0) && v[WIDTH-1]}}, v};
   endfunction

   // One extra bit makes the sum exact; overflow shows up in the top bits.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {(SIGN != 0) && a[ACC_W-1], a} + {(SIGN != 0) && b[ACC_W-1], b};
      if (SIGN != 0) begin
         if (sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
      end else if (sum[ACC_W]) begin
         return '1;
      end
      return sum[ACC_W-1:0];
   endfunction

   fp_saturate #(
      .SIGN  (SIGN),
      .WIDTH (WIDTH),
      .ACC_W (ACC_W),
      .RELU  (RELU)
   ) u_saturate (
      .acc  (acc_q),
      .data (clamp_data),
      .sat  (clamp_sat)
   );

   assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
   assign beat      = in_valid && in_ready;
   assign out_valid = (state_q == OUT);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign out_terms = out_terms_q;

   // Next-state and datapath updates; the bias only enters on the first beat.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      terms_d     = terms_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_terms_d = out_terms_q;
      case (state_q)
         IDLE: begin
            if (beat) begin
               acc_d   = sat_add(ext(bias), ext(in_product));
               terms_d = TERM_W'(1);
               state_d = in_last ? ACTIVATE : ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d = sat_add(acc_q, ext(in_product));
               if (terms_q != '1)
                  terms_d = terms_q + 1'b1;
               if (in_last)
                  state_d = ACTIVATE;
            end
         end
         ACTIVATE: begin
            out_data_d  = clamp_data;
            out_sat_d   = clamp_sat;
            out_terms_d = terms_q;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         terms_q     <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         out_terms_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         terms_q     <= terms_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_terms_q <= out_terms_d;
      end
   end

endmodule
